adder64_acc_stage: RTL and testbench

//  Sequential accumulate stage built around adder64. Takes a valid/ready stream of 64-bit

---
 rtl/adder64_acc_stage.sv | 172 +++++++++++++++++
 tb/tb_adder64_acc_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder64_acc_stage.sv
// Packet accumulator: sums a valid/ready stream of 64-bit operands through adder64 and presents one
// result per packet. Optional signed-overflow tracking is enabled by defining ADDER64_ACC_SOVF_EN.

module adder64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
    output logic        c64
);
    logic [63:0] g;
    logic [63:0] p;
    logic [16:0] gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = cin;
    assign c64   = gc[16];

    // 4-bit lookahead groups, group carries rippled between groups
    for (genvar k = 0; k < 16; k++) begin : g_grp
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;

        assign c[0] = gc[k];
        assign c[1] = g[4*k] | (p[4*k] & c[0]);
        assign c[2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[0]);
        assign c[3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                    | (p[4*k+2] & p[4*k+1] & p[4*k] & c[0]);

        assign grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        assign grp_p = &p[4*k+3 -: 4];
        assign gc[k+1] = grp_g | (grp_p & c[0]);

        assign s[4*k+3 -: 4] = p[4*k+3 -: 4] ^ c;
    end
endmodule

module adder64_acc_stage #(
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic [CNT_W-1:0] out_terms,
    output logic             out_trunc,
    output logic             out_sovf
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [63:0]      acc, acc_next;
    logic [CNT_W-1:0] terms, terms_next;
    logic [CNT_W-1:0] carry_cnt, carry_cnt_next;
    logic             trunc, trunc_next;

    logic [63:0]      adder_a;
    logic [63:0]      sum;
    logic             c64;
    logic             accept;
    logic [CNT_W-1:0] terms_inc;

    // first beat of a packet adds onto zero, so its carry-out is meaningless
    assign adder_a = (state == ACCUM) ? acc : '0;

    adder64 u_adder (
        .a   (adder_a),
        .b   (in_data),
        .cin (1'b0),
        .s   (sum),
        .c64 (c64)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign terms_inc = (state == IDLE) ? CNT_W'(1) : terms + CNT_W'(1);

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        terms_next     = terms;
        carry_cnt_next = carry_cnt;
        trunc_next     = trunc;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_next   = sum;
                    terms_next = terms_inc;
                    if (state == IDLE) begin
                        carry_cnt_next = '0;
                    end else if (c64 && (carry_cnt != '1)) begin
                        carry_cnt_next = carry_cnt + CNT_W'(1);
                    end
                    if (in_last || (terms_inc == CNT_W'(MAX_TERMS))) begin
                        state_next = HOLD;
                        trunc_next = !in_last;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    acc_next       = '0;
                    terms_next     = '0;
                    carry_cnt_next = '0;
                    trunc_next     = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            terms     <= '0;
            carry_cnt <= '0;
            trunc     <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            terms     <= terms_next;
            carry_cnt <= carry_cnt_next;
            trunc     <= trunc_next;
        end
    end

    assign out_sum       = acc;
    assign out_carry_cnt = carry_cnt;
    assign out_terms     = terms;
    assign out_trunc     = trunc;

`ifdef ADDER64_ACC_SOVF_EN
    logic sovf, sovf_next;

    always_comb begin
        sovf_next = sovf;
        if (state == HOLD) begin
            if (out_ready) sovf_next = 1'b0;
        end else if (accept && (state == ACCUM)) begin
            if ((acc[63] == in_data[63]) && (sum[63] != acc[63])) sovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sovf <= 1'b0;
        else        sovf <= sovf_next;
    end

    assign out_sovf = sovf;
`else
    assign out_sovf = 1'b0;
`endif
endmodule

// File: tb/tb_adder64_acc_stage.sv
// Directed bench for adder64_acc_stage: packet-level reference model checked every cycle,
// plus literal expectations per directed packet.

module tb_adder64_acc_stage;
    localparam int unsigned MAX_TERMS = 16;
    localparam int unsigned CNT_W     = 8;
`ifdef ADDER64_ACC_SOVF_EN
    localparam bit SOVF_ON = 1'b1;
`else
    localparam bit SOVF_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_sum;
    logic [CNT_W-1:0] out_carry_cnt;
    logic [CNT_W-1:0] out_terms;
    logic             out_trunc;
    logic             out_sovf;

    int total = 0;
    int bad   = 0;

    adder64_acc_stage #(.MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_carry_cnt (out_carry_cnt),
        .out_terms     (out_terms),
        .out_trunc     (out_trunc),
        .out_sovf      (out_sovf)
    );

    always #5 clk = ~clk;

    // Packet-level reference model
    logic [63:0]        m_sum;
    int                 m_cc;
    int                 m_terms;
    logic               m_trunc;
    logic               m_sovf;
    logic               m_hold;
    logic [64:0]        m_wide;
    logic signed [64:0] m_swide;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum = '0; m_cc = 0; m_terms = 0; m_trunc = 1'b0; m_sovf = 1'b0; m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_sum = '0; m_cc = 0; m_terms = 0; m_trunc = 1'b0; m_sovf = 1'b0; m_hold = 1'b0;
            end
        end else if (in_valid) begin
            if (m_terms == 0) begin
                m_sum = in_data;
                m_cc  = 0;
            end else begin
                m_wide  = {1'b0, m_sum} + {1'b0, in_data};
                m_swide = $signed({m_sum[63], m_sum}) + $signed({in_data[63], in_data});
                if (m_swide[64] != m_swide[63]) m_sovf = 1'b1;
                if (m_wide[64] && m_cc < 255) m_cc = m_cc + 1;
                m_sum = m_wide[63:0];
            end
            m_terms = m_terms + 1;
            if (in_last || m_terms == MAX_TERMS) begin
                m_hold  = 1'b1;
                m_trunc = !in_last;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(in_ready), 64'(!m_hold));
            chk("out_valid", 64'(out_valid), 64'(m_hold));
            if (m_hold) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_carry_cnt", 64'(out_carry_cnt), 64'(m_cc));
                chk("out_terms", 64'(out_terms), 64'(m_terms));
                chk("out_trunc", 64'(out_trunc), 64'(m_trunc));
                chk("out_sovf", 64'(out_sovf), 64'(SOVF_ON & m_sovf));
            end
        end
    end

    task automatic send(input logic [63:0] data, input logic last);
        bit ok = 0;
        bit ready_now;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            ready_now = in_ready;
            @(posedge clk); #1;
            if (ready_now) ok = 1;
        end
        in_valid = 1'b0;
        chk("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic expect_res(input string name, input logic [63:0] sum, input int cc,
                              input int terms, input logic trunc, input logic sovf);
        chk({name, "_sum"}, out_sum, sum);
        chk({name, "_cc"}, 64'(out_carry_cnt), 64'(cc));
        chk({name, "_terms"}, 64'(out_terms), 64'(terms));
        chk({name, "_trunc"}, 64'(out_trunc), 64'(trunc));
        chk({name, "_sovf"}, 64'(out_sovf), 64'(sovf));
        chk({name, "_model_sum"}, m_sum, sum);
        chk({name, "_model_terms"}, 64'(m_terms), 64'(terms));
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_ready"}, 64'(in_ready), 64'd1);
        chk({name, "_sum"}, out_sum, 64'd0);
        chk({name, "_cc"}, 64'(out_carry_cnt), 64'd0);
        chk({name, "_terms"}, 64'(out_terms), 64'd0);
        chk({name, "_trunc"}, 64'(out_trunc), 64'd0);
        chk({name, "_sovf"}, 64'(out_sovf), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: two-beat packet, latency
        send(64'd114514, 1'b0);
        chk("t1_no_early_valid", 64'(out_valid), 64'd0);
        send(64'd10086, 1'b1);
        chk("t1_latency", 64'(out_valid), 64'd1);
        expect_res("t1", 64'd124600, 0, 2, 1'b0, 1'b0);
        handshake("t1");

        // 2: back-pressure holds outputs
        send(64'd123456, 1'b0);
        send(64'd345678, 1'b1);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            expect_res("t2_hold", 64'd469134, 0, 2, 1'b0, 1'b0);
            chk("t2_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        handshake("t2");

        // 3: carry counting
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd2, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wait_valid();
        expect_res("t3", 64'd0, 2, 3, 1'b0, 1'b0);
        handshake("t3");

        // 4: force-close at MAX_TERMS, 17th beat stalls then forms a one-beat packet
        for (int i = 0; i < 16; i++) send(64'd1, 1'b0);
        chk("t4_closed", 64'(out_valid), 64'd1);
        expect_res("t4", 64'd16, 0, 16, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 64'd1; in_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("t4_stall", 64'(in_ready), 64'd0);
            expect_res("t4_stall", 64'd16, 0, 16, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t4_back_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expect_res("t4_single", 64'd1, 0, 1, 1'b0, 1'b0);
        handshake("t4");

        // 5: reset mid-packet
        send(64'd9, 1'b0);
        send(64'd11, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_all_zero("t5_after");
        send(64'd5, 1'b0);
        send(64'd7, 1'b1);
        expect_res("t5", 64'd12, 0, 2, 1'b0, 1'b0);
        handshake("t5");

        // 6: signed overflow
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd1, 1'b1);
        expect_res("t6", 64'h8000_0000_0000_0000, 0, 2, 1'b0, SOVF_ON);
        handshake("t6");
        chk("t6_sovf_cleared", 64'(out_sovf), 64'd0);

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
